// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared widths and the command record for the shift-command
//                queue that feeds the 8-bit barrel shifter.
//                  DATA_W  - operand width (shifter IN/OUT)
//                  SHIFT_W - shift amount width (2**SHIFT_W == DATA_W)
//                  CMD_W   - width of one packed queue entry
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    localparam int DATA_W  = 8;
    localparam int SHIFT_W = 3;
    localparam int CMD_W   = DATA_W + 1 + SHIFT_W;

    // One queued command. Field order matches the storage bit layout
    // {data, dir, shift}, data in the MSBs.
    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               dir;    // 1 = right, 0 = left
        logic [SHIFT_W-1:0] shift;
    } shift_cmd_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_cmd_mem.sv
`default_nettype none
// ============================================================================
//  Module      : shift_cmd_mem
//  Description : DEPTH x W register array, one synchronous write port and one
//                asynchronous read port. Storage carries no reset: an entry is
//                only observed after it has been written, and the queue
//                control forces the outputs to zero while empty.
//  Ports       : clk            - rising-edge clock
//                we/waddr/wdata - write strobe, address, data
//                raddr/rdata    - combinational read address and data
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_cmd_mem
    import shift_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = CMD_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : shift_cmd_mem
`default_nettype wire

// File: rtl/shift_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : shift_cmd_fifo
//  Description : First-word fall-through valid/ready queue of shift commands
//                (data, direction, amount) in front of the combinational
//                barrel shifter. The head entry drives the shifter directly.
//  Ports       : clk, rst_n                  - clock, async active-low reset
//                in_valid/in_ready           - producer handshake
//                in_data/in_dir/in_shift     - command pushed
//                out_valid/out_ready         - shifter-side handshake
//                out_data/out_dir/out_shift  - head command (0 while empty)
//                level                       - occupancy 0..DEPTH
//  Config      : SHIFT_CMD_LEVEL_EN - when defined, the level port exists and
//                reflects the registered occupancy; otherwise it is absent.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_cmd_fifo
    import shift_pkg::*;
#(
    parameter int DATA_W  = shift_pkg::DATA_W,
    parameter int SHIFT_W = shift_pkg::SHIFT_W,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_dir,
    input  logic [SHIFT_W-1:0] in_shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_dir,
`ifdef SHIFT_CMD_LEVEL_EN
    output logic [SHIFT_W-1:0] out_shift,
    output logic [$clog2(DEPTH):0] level
`else
    output logic [SHIFT_W-1:0] out_shift
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int W  = DATA_W + 1 + SHIFT_W;

    localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_push;
    logic          w_pop;
    logic [W-1:0]  w_head;

    // Both flags come from registered state only: a pop in the same cycle
    // does not open a slot for a push while full.
    assign in_ready  = (r_count != c_full);
    assign out_valid = (r_count != '0);

    assign w_push = in_valid  & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are exactly AW bits wide, so the increment wraps
            // DEPTH-1 -> 0 on its own (DEPTH is a power of two).
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    shift_cmd_mem #(
        .DEPTH (DEPTH),
        .W     (W),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata ({in_data, in_dir, in_shift}),
        .raddr (r_rd_ptr),
        .rdata (w_head)
    );

    // Head fields are masked while empty so the shifter never sees stale
    // storage contents (including right after a flush).
    assign out_data  = out_valid ? w_head[W-1 -: DATA_W]   : '0;
    assign out_dir   = out_valid ? w_head[SHIFT_W]          : 1'b0;
    assign out_shift = out_valid ? w_head[SHIFT_W-1:0]      : '0;

`ifdef SHIFT_CMD_LEVEL_EN
    assign level = r_count;
`endif

endmodule : shift_cmd_fifo
`default_nettype wire

// File: tb/tb_shift_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_cmd_fifo
//  Description : Self-checking bench for shift_cmd_fifo. A queue-based model
//                tracks the expected contents; outputs are compared on every
//                falling edge, and directed scenarios add literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_cmd_fifo;
    import shift_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_dir = 1'b0;
    logic [2:0] in_shift = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_dir;
    logic [2:0] out_shift;
`ifdef SHIFT_CMD_LEVEL_EN
    logic [2:0] level;
`endif

    int checks = 0;
    int errors = 0;

    shift_cmd_t mq[$];
    shift_cmd_t popped[$];

    shift_cmd_fifo #(.DATA_W(8), .SHIFT_W(3), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_shift  (in_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_dir   (out_dir),
`ifdef SHIFT_CMD_LEVEL_EN
        .out_shift (out_shift),
        .level     (level)
`else
        .out_shift (out_shift)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] shifter(input logic [7:0] d, input logic dir, input logic [2:0] sh);
        return dir ? (d >> sh) : (d << sh);
    endfunction

    // Model: plain queue. Pop the old head first, then append the push.
    always @(posedge clk) begin
        bit p;
        bit q;
        if (rst_n) begin
            p = in_valid && (mq.size() < DEPTH);
            q = out_ready && (mq.size() > 0);
            if (q) popped.push_back(mq.pop_front());
            if (p) mq.push_back('{data: in_data, dir: in_dir, shift: in_shift});
        end
    end

    always @(negedge rst_n) mq.delete();

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
            if (mq.size() != 0) begin
                chk("out_data", 32'(out_data), 32'(mq[0].data));
                chk("out_dir", 32'(out_dir), 32'(mq[0].dir));
                chk("out_shift", 32'(out_shift), 32'(mq[0].shift));
            end else begin
                chk("out_data_empty", 32'(out_data), 32'h0);
                chk("out_dir_empty", 32'(out_dir), 32'h0);
                chk("out_shift_empty", 32'(out_shift), 32'h0);
            end
`ifdef SHIFT_CMD_LEVEL_EN
            chk("level", 32'(level), 32'(mq.size()));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic dir, input logic [2:0] sh);
        bit accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dir;
        in_shift = sh;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            accepted = in_ready;
            cyc();
        end
        in_valid = 1'b0;
        if (!accepted) chk("push_timeout", 32'h0, 32'h1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (out_valid && n < 50) begin
            cyc();
            n++;
        end
        out_ready = 1'b0;
        if (n >= 50) chk("drain_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        // 1. Reset state
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
`ifdef SHIFT_CMD_LEVEL_EN
        chk("rst_level", 32'(level), 32'h0);
`endif
        #11 rst_n = 1'b1;
        cyc();

        // 2. Single push, visible next cycle
        push(8'hA5, 1'b1, 3'd3);
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_data", 32'(out_data), 32'hA5);
        chk("single_dir", 32'(out_dir), 32'h1);
        chk("single_shift", 32'(out_shift), 32'h3);
        chk("single_shifter", 32'(shifter(out_data, out_dir, out_shift)), 32'h14);
        drain();

        // 3 + 5. Fill, hold a 5th, full with out_ready, drain in order
        popped.delete();
        push(8'h11, 1'b0, 3'd1);
        push(8'h22, 1'b1, 3'd2);
        push(8'h33, 1'b0, 3'd7);
        push(8'h44, 1'b1, 3'd0);
        chk("full_in_ready", 32'(in_ready), 32'h0);
        in_valid = 1'b1; in_data = 8'h55; in_dir = 1'b1; in_shift = 3'd5;
        cyc();
        cyc();
        chk("held_in_ready", 32'(in_ready), 32'h0);
        chk("model_full", 32'(mq.size()), 32'd4);
`ifdef SHIFT_CMD_LEVEL_EN
        chk("full_level", 32'(level), 32'd4);
`endif
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_in_ready", 32'(in_ready), 32'h0);
        cyc();
        chk("after_pop_in_ready", 32'(in_ready), 32'h1);
        cyc();
        in_valid = 1'b0;
        drain();
        chk("order_count", 32'(popped.size()), 32'd5);
        if (popped.size() == 5) begin
            chk("order0", 32'(popped[0].data), 32'h11);
            chk("order1", 32'(popped[1].data), 32'h22);
            chk("order2", 32'(popped[2].data), 32'h33);
            chk("order3", 32'(popped[3].data), 32'h44);
            chk("order4", 32'(popped[4].data), 32'h55);
            chk("order4_shift", 32'(popped[4].shift), 32'h5);
        end

        // 4. Simultaneous push/pop at count=2 across pointer wrap
        popped.delete();
        push(8'h60, 1'b0, 3'd6);
        push(8'h61, 1'b1, 3'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data  = 8'(8'h70 + i);
            in_dir   = i[0];
            in_shift = i[2:0];
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pp_model_count", 32'(mq.size()), 32'd2);
        chk("pp_out_valid", 32'(out_valid), 32'h1);
        chk("pp_in_ready", 32'(in_ready), 32'h1);
        chk("pp_head", 32'(out_data), 32'h78);
        drain();
        chk("pp_popped", 32'(popped.size()), 32'd12);
        if (popped.size() == 12) begin
            chk("pp_first", 32'(popped[0].data), 32'h60);
            chk("pp_last", 32'(popped[11].data), 32'h79);
        end

        // 6. Async reset mid-burst
        push(8'hA1, 1'b0, 3'd1);
        push(8'hA2, 1'b0, 3'd2);
        push(8'hA3, 1'b0, 3'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_in_ready", 32'(in_ready), 32'h1);
        chk("arst_out_data", 32'(out_data), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc();
        chk("post_rst_empty", 32'(out_valid), 32'h0);
        push(8'hB7, 1'b0, 3'd5);
        chk("post_rst_data", 32'(out_data), 32'hB7);
        chk("post_rst_shift", 32'(out_shift), 32'h5);
        chk("post_rst_shifter", 32'(shifter(out_data, out_dir, out_shift)), 32'hE0);
        drain();
        chk("end_empty", 32'(out_valid), 32'h0);

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_shift_cmd_fifo
`default_nettype wire
